// File: rtl/frame_rr_scheduler.sv
// Round-robin frame scheduler: grants one channel FIFO holding >= FRAME_LEN words, drains one whole frame.
// Latency: rdreq in cycle t -> out_valid at t+2 at the earliest; 1 word/clk sustained while out_ready = 1.
// Backpressure: reads are credited against a 2-entry skid; rdreq drops as soon as skid + in-flight would overflow.
module frame_rr_scheduler #(
   parameter int NCH       = 4,
   parameter int DW        = 64,
   parameter int UW        = 13,
   parameter int FRAME_LEN = 128
) (
   input  logic                   rdclk,
   input  logic                   rst_n,
   input  logic [NCH*UW-1:0]      rdusedw,
   input  logic [NCH*DW-1:0]      q,
   output logic [NCH-1:0]         rdreq,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [DW-1:0]          out_data,
   output logic [$clog2(NCH)-1:0] out_ch,
   output logic                   out_sof,
   output logic                   out_eof,
   output logic                   busy
);
   localparam int CHW = $clog2(NCH);
   localparam int CW  = $clog2(FRAME_LEN + 1);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   // One skid entry: word plus its channel tag and frame markers.
   typedef struct packed {
      logic [DW-1:0]  dat;
      logic [CHW-1:0] ch;
      logic           sof;
      logic           eof;
   } ent_t;

   state_t         state_q, state_d;
   logic [CHW-1:0] grant_q, grant_d;
   logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]  issue_cnt_q, issue_cnt_d;
   logic           infl_q, infl_d;
   logic           infl_sof_q, infl_sof_d;
   logic           infl_eof_q, infl_eof_d;
   ent_t           skid_q [2];
   ent_t           skid_d [2];
   logic           wr_ptr_q, wr_ptr_d;
   logic           rd_ptr_q, rd_ptr_d;
   logic [1:0]     occ_q, occ_d;

   logic           found;
   logic [CHW-1:0] pick;
   logic [1:0]     fill;
   logic           credit_ok;
   logic           push;
   logic           pop;
   ent_t           head;

   assign head      = skid_q[rd_ptr_q];
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = head.dat;
   assign out_ch    = head.ch;
   assign out_sof   = head.sof;
   assign out_eof   = head.eof;
   assign busy      = (state_q != IDLE);
   assign pop       = out_valid && out_ready;
   assign push      = infl_q;

   // A read may issue only if the skid can hold every word already owed to it.
   assign fill      = occ_q + {1'b0, infl_q};
   assign credit_ok = (fill < 2'd2) || ((fill == 2'd2) && pop);

   // Round-robin search starting just after the last served channel.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      for (int k = 1; k <= NCH; k++) begin
         if (!found && (rdusedw[((int'(rr_ptr_q) + k) % NCH)*UW +: UW] >= UW'(FRAME_LEN))) begin
            found = 1'b1;
            pick  = CHW'((int'(rr_ptr_q) + k) % NCH);
         end
      end
   end

   // Frame FSM: grant in IDLE, issue FRAME_LEN reads in BURST, wait for EOF acceptance in DRAIN.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      issue_cnt_d = issue_cnt_q;
      rdreq       = '0;
      infl_d      = 1'b0;
      infl_sof_d  = 1'b0;
      infl_eof_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d     = pick;
               issue_cnt_d = '0;
               state_d     = BURST;
            end
         end
         BURST: begin
            if (credit_ok) begin
               rdreq[grant_q] = 1'b1;
               infl_d         = 1'b1;
               infl_sof_d     = (issue_cnt_q == '0);
               infl_eof_d     = (issue_cnt_q == CW'(FRAME_LEN - 1));
               issue_cnt_d    = issue_cnt_q + CW'(1);
               if (issue_cnt_q == CW'(FRAME_LEN - 1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && head.eof) begin
               rr_ptr_d = grant_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Skid: capture the word returned one cycle after rdreq, pop on handshake, both allowed together.
   always_comb begin
      skid_d   = skid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         skid_d[wr_ptr_q] = '{dat: q[grant_q*DW +: DW], ch: grant_q, sof: infl_sof_q, eof: infl_eof_q};
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // State registers; reset discards any partial frame and gives channel 0 first priority.
   always_ff @(posedge rdclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= CHW'(NCH - 1);
         issue_cnt_q <= '0;
         infl_q      <= 1'b0;
         infl_sof_q  <= 1'b0;
         infl_eof_q  <= 1'b0;
         skid_q      <= '{default: '0};
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         issue_cnt_q <= issue_cnt_d;
         infl_q      <= infl_d;
         infl_sof_q  <= infl_sof_d;
         infl_eof_q  <= infl_eof_d;
         skid_q      <= skid_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
      end
   end

endmodule

// File: tb/tb_frame_rr_scheduler.sv
// Bench for frame_rr_scheduler: directed scenarios, expected words queued per frame, checked by a monitor.
// FIFO model returns q one cycle after rdreq; data = {channel, frame number, word index}.
// Monitor pops the expected queue on every accepted output word.
`timescale 1ns/1ps
module tb_frame_rr_scheduler;
   localparam int NCH = 4;
   localparam int DW  = 64;
   localparam int UW  = 13;
   localparam int FL  = 128;

   typedef logic [DW+3:0] word_t;   // {data, ch[1:0], sof, eof}

   logic              rdclk = 1'b0;
   logic              rst_n;
   logic [NCH*UW-1:0] rdusedw;
   logic [NCH*DW-1:0] q;
   logic [NCH-1:0]    rdreq;
   logic              out_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_ch;
   logic              out_sof;
   logic              out_eof;
   logic              busy;

   word_t exp_q[$];
   int    n_checks  = 0;
   int    n_pass    = 0;
   int    acc_words = 0;
   int    sof_seen  = 0;
   int    rd_cnt  [NCH];
   int    exp_frm [NCH];

   always #5 rdclk = ~rdclk;

   frame_rr_scheduler #(.NCH(NCH), .DW(DW), .UW(UW), .FRAME_LEN(FL)) dut (
      .rdclk(rdclk), .rst_n(rst_n), .rdusedw(rdusedw), .q(q), .rdreq(rdreq),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_sof(out_sof), .out_eof(out_eof), .busy(busy)
   );

   function automatic logic [DW-1:0] pat(int c, int n);
      return {8'(c), 24'(n / FL), 32'(n % FL)};
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic push_frame(int c);
      for (int w = 0; w < FL; w++) begin
         exp_q.push_back({pat(c, exp_frm[c]*FL + w), 2'(c), (w == 0), (w == FL-1)});
      end
      exp_frm[c]++;
   endtask

   task automatic set_lvl(int c, int v);
      rdusedw[c*UW +: UW] = UW'(v);
   endtask

   task automatic wait_idle(string name);
      int k = 0;
      while ((exp_q.size() != 0 || busy) && k < 3000) begin
         @(negedge rdclk);
         k++;
      end
      chk(name, (exp_q.size() == 0 && !busy), 1);
   endtask

   task automatic wait_sof(int target, string name);
      int k = 0;
      while (sof_seen < target && k < 3000) begin
         @(negedge rdclk);
         k++;
      end
      chk(name, (sof_seen >= target), 1);
   endtask

   task automatic wait_words(int target, string name);
      int k = 0;
      while (acc_words < target && k < 3000) begin
         @(negedge rdclk);
         k++;
      end
      chk(name, (acc_words >= target), 1);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      rdusedw   = '0;
      repeat (3) @(negedge rdclk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rdreq", rdreq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_fields", {out_data, out_ch, out_sof, out_eof}, 0);
      exp_q.delete();
      for (int c = 0; c < NCH; c++) begin
         rd_cnt[c]  = 0;
         exp_frm[c] = 0;
      end
      rst_n = 1'b1;
   endtask

   // FIFO model: a read seen during a cycle produces q just after the following edge.
   initial begin : fifo_model
      logic [NCH-1:0] rq;
      q = '0;
      forever begin
         @(negedge rdclk);
         rq = rdreq;
         @(posedge rdclk);
         #1;
         for (int c = 0; c < NCH; c++) begin
            if (rq[c]) begin
               q[c*DW +: DW] = pat(c, rd_cnt[c]);
               rd_cnt[c]++;
            end
         end
      end
   end

   // Monitor: every accepted word is compared against the head of the expected queue.
   initial begin : monitor
      word_t e;
      forever begin
         @(negedge rdclk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got data=%h ch=%0d, expected no word", out_data, out_ch);
            end else begin
               e = exp_q.pop_front();
               chk("out_word", {out_data, out_ch, out_sof, out_eof}, e);
            end
            acc_words++;
            if (out_sof) sof_seen++;
         end
      end
   end

   initial begin : stim
      int run;
      int base;
      int viol;
      do_reset();

      // 1: single frame on channel 0, check grant latency, read run length and output latency.
      push_frame(0);
      @(negedge rdclk);
      set_lvl(0, 128);
      @(negedge rdclk);
      chk("t1_first_rdreq", rdreq, 4'b0001);
      run = 1;
      for (int k = 1; k < 400; k++) begin
         @(negedge rdclk);
         if (k == 1) chk("t1_valid_t+1", out_valid, 0);
         if (k == 2) chk("t1_valid_t+2", out_valid, 1);
         if (rdreq == 4'b0001) run++;
         else break;
      end
      chk("t1_rdreq_run", run, 128);
      chk("t1_rdreq_after", rdreq, 0);
      set_lvl(0, 0);
      wait_idle("t1_idle");
      chk("t1_busy", busy, 0);
      chk("t1_out_valid", out_valid, 0);

      // 2: all channels full and held, from reset: order 0,1,2,3,0.
      do_reset();
      push_frame(0); push_frame(1); push_frame(2); push_frame(3); push_frame(0);
      base = sof_seen;
      @(negedge rdclk);
      for (int c = 0; c < NCH; c++) set_lvl(c, 128);
      wait_sof(base + 5, "t2_five_frames");
      rdusedw = '0;
      wait_idle("t2_idle");

      // 3: out_ready toggling every cycle on channel 1.
      push_frame(1);
      base = sof_seen;
      run  = rd_cnt[1];
      @(negedge rdclk);
      set_lvl(1, 128);
      viol = 0;
      while ((exp_q.size() != 0 || busy) && viol < 3000) begin
         @(posedge rdclk);
         #1;
         out_ready = ~out_ready;
         viol++;
         if (sof_seen > base) set_lvl(1, 0);
      end
      out_ready = 1'b1;
      chk("t3_drained", (exp_q.size() == 0 && !busy), 1);
      chk("t3_reads", rd_cnt[1] - run, 128);

      // 4: 50-cycle stall mid-frame on channel 3.
      push_frame(3);
      base = acc_words;
      @(negedge rdclk);
      set_lvl(3, 128);
      wait_words(base + 40, "t4_reach_word40");
      set_lvl(3, 0);
      @(posedge rdclk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge rdclk);
         chk("t4_rdreq_stopped", rdreq, 0);
         chk("t4_valid_held", out_valid, 1);
         chk("t4_word_held", {out_data, out_ch, out_sof, out_eof}, exp_q[0]);
      end
      @(posedge rdclk);
      #1;
      out_ready = 1'b1;
      wait_idle("t4_idle");

      // 5: 127 words is below threshold; 300 gets exactly one frame.
      @(negedge rdclk);
      set_lvl(2, 127);
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge rdclk);
         if (busy || rdreq != 0) viol++;
      end
      chk("t5_no_grant_127", viol, 0);
      push_frame(2);
      base = sof_seen;
      run  = rd_cnt[2];
      set_lvl(2, 300);
      wait_sof(base + 1, "t5_granted");
      set_lvl(2, 0);
      wait_idle("t5_idle");
      chk("t5_reads", rd_cnt[2] - run, 128);

      // 6: reset at word 60 of a channel 0 frame.
      push_frame(0);
      base = acc_words;
      @(negedge rdclk);
      set_lvl(0, 128);
      wait_words(base + 60, "t6_reach_word60");
      @(posedge rdclk);
      #1;
      rst_n = 1'b0;
      @(negedge rdclk);
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_rdreq", rdreq, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_fields", {out_data, out_ch, out_sof, out_eof}, 0);
      exp_q.delete();
      rdusedw = '0;
      repeat (2) @(negedge rdclk);
      rst_n = 1'b1;
      viol = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge rdclk);
         if (busy || out_valid || rdreq != 0) viol++;
      end
      chk("t6_quiet_after_reset", viol, 0);
      chk("t6_busy", busy, 0);
      chk("t6_out_valid", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
